pipeline_ctrl_unit: RTL and testbench

Parametrised central pipeline controller for the 5-stage (IF/ID/EX/MEM/WB) RISC core. It replaces the scattered stall, flush and forwarding logic with one block. The block keeps its own per-stage shadow of validity, destination and source registers, and from that shadow it drives stall, flush and bubble enables plus operand-forwarding selects. It adds three behaviours: multi-cycle EX operations with a configurable latency, an optional hard-wired zero register, and a debug halt/single-step FSM.

---
 rtl/pipeline_ctrl_unit.sv | 201 ++++++++++++++++++++
 tb/tb_pipeline_ctrl_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_unit.sv
// Central stall/flush/forwarding controller for the 5-stage core, with multi-cycle EX ops and debug halt/step.
// Latency: enables, bubbles and forward selects are combinational from inputs and shadow state; ex_busy/dbg_halted are state-derived.
// Backpressure: stalls PC/IF-ID (load-use, drain), freezes EX and bubbles EX/MEM while a multi-cycle op is busy.
// Ports: clk/reset (sync, active-high); id_* = decoded ID-stage instruction; ex_branch_taken, dbg_halt_req, dbg_step in;
//        pc_write/ifid_write/idex_write enables, ifid_flush/idex_bubble/exmem_bubble NOP inserts, forward_a/b selects,
//        ex_busy and dbg_halted status out.
module pipeline_ctrl_unit #(
  parameter int REG_AW   = 3,
  parameter int MC_LAT   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_multicycle,
  input  logic              ex_branch_taken,
  input  logic              dbg_halt_req,
  input  logic              dbg_step,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_bubble,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              ex_busy,
  output logic              dbg_halted
);

  localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] MC_LOAD = CW'(MC_LAT - 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED, ST_STEP} dbg_state_t;

  dbg_state_t r_state;
  dbg_state_t w_state_nxt;

  // Shadow of the datapath pipeline registers
  logic              r_v_id;
  logic              r_v_ex;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_rw;
  logic              r_ex_mr;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic              r_ex_use1;
  logic              r_ex_use2;
  logic              r_v_mem;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_rw;
  logic              r_v_wb;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_rw;
  logic [CW-1:0]     r_cnt;

  logic w_busy;
  logic w_load_use;
  logic w_dbg_hold;
  logic w_drained;
  logic w_issue;

  // A stage supplies src only if it really writes it; register 0 is excluded when hard-wired.
  function automatic logic f_match(input logic v, input logic rw,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] src);
    f_match = v && rw && (rd == src) && !((ZERO_REG != 0) && (rd == '0));
  endfunction

  assign w_busy  = (r_cnt != '0);
  assign ex_busy = w_busy;

  assign w_load_use = r_v_id && r_ex_mr &&
                      ((id_use_rs1 && f_match(r_v_ex, r_ex_rw, r_ex_rd, id_rs1)) ||
                       (id_use_rs2 && f_match(r_v_ex, r_ex_rw, r_ex_rd, id_rs2)));

  // The halt request starts draining in the same cycle it is seen in RUN.
  assign w_dbg_hold = ((r_state == ST_RUN) && dbg_halt_req) ||
                      (r_state == ST_DRAIN) || (r_state == ST_HALTED);

  assign w_drained  = !r_v_ex && !r_v_mem && !r_v_wb && !w_busy;
  assign w_issue    = r_v_id && idex_write && !idex_bubble;
  assign dbg_halted = (r_state == ST_HALTED);

  // Enables in priority order: busy > branch > load-use > debug drain > run
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (reset) begin
      // idle enables while reset is held
    end else if (w_busy) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_load_use || w_dbg_hold) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Forward selects for the instruction currently in EX; MEM/stage result wins over WB.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (r_v_ex && r_ex_use1) begin
      if (f_match(r_v_mem, r_mem_rw, r_mem_rd, r_ex_rs1))     forward_a = 2'b01;
      else if (f_match(r_v_wb, r_wb_rw, r_wb_rd, r_ex_rs1))   forward_a = 2'b10;
    end
    if (r_v_ex && r_ex_use2) begin
      if (f_match(r_v_mem, r_mem_rw, r_mem_rd, r_ex_rs2))     forward_b = 2'b01;
      else if (f_match(r_v_wb, r_wb_rw, r_wb_rd, r_ex_rs2))   forward_b = 2'b10;
    end
  end

  // Debug FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (dbg_halt_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!dbg_halt_req) w_state_nxt = ST_RUN;
                 else if (w_drained) w_state_nxt = ST_HALTED;
      ST_HALTED: if (!dbg_halt_req) w_state_nxt = ST_RUN;
                 else if (dbg_step) w_state_nxt = ST_STEP;
      // Stay in run mode until the held ID instruction actually issues (load-use may delay it).
      ST_STEP:   if (w_issue) w_state_nxt = ST_DRAIN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_v_id    <= 1'b0;
      r_v_ex    <= 1'b0;
      r_ex_rd   <= '0;
      r_ex_rw   <= 1'b0;
      r_ex_mr   <= 1'b0;
      r_ex_rs1  <= '0;
      r_ex_rs2  <= '0;
      r_ex_use1 <= 1'b0;
      r_ex_use2 <= 1'b0;
      r_v_mem   <= 1'b0;
      r_mem_rd  <= '0;
      r_mem_rw  <= 1'b0;
      r_v_wb    <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_rw   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (ifid_flush)      r_v_id <= 1'b0;
      else if (ifid_write) r_v_id <= 1'b1;

      if (idex_bubble) begin
        r_v_ex <= 1'b0;
        r_cnt  <= '0;
      end else if (idex_write) begin
        r_v_ex    <= r_v_id;
        r_ex_rd   <= id_rd;
        r_ex_rw   <= id_regwrite;
        r_ex_mr   <= id_memread;
        r_ex_rs1  <= id_rs1;
        r_ex_rs2  <= id_rs2;
        r_ex_use1 <= id_use_rs1;
        r_ex_use2 <= id_use_rs2;
        r_cnt     <= (r_v_id && id_multicycle) ? MC_LOAD : '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt - CW'(1);
      end

      if (exmem_bubble) begin
        r_v_mem <= 1'b0;
      end else begin
        r_v_mem  <= r_v_ex;
        r_mem_rd <= r_ex_rd;
        r_mem_rw <= r_ex_rw;
      end

      r_v_wb  <= r_v_mem;
      r_wb_rd <= r_mem_rd;
      r_wb_rw <= r_mem_rw;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
module tb_pipeline_ctrl_unit;

  localparam int AW  = 3;
  localparam int LAT = 4;
  localparam int ZR  = 1;

  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2, M_STEP = 3;

  typedef struct packed {
    logic          v;
    logic [7:0]    tag;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic          rw;
    logic          mr;
    logic          mc;
    logic          br;
  } instr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_regwrite, id_memread, id_multicycle;
  logic          ex_branch_taken, dbg_halt_req, dbg_step;
  logic          pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble;
  logic [1:0]    forward_a, forward_b;
  logic          ex_busy, dbg_halted;

  always #5 clk = ~clk;

  pipeline_ctrl_unit #(.REG_AW(AW), .MC_LAT(LAT), .ZERO_REG(ZR)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_multicycle(id_multicycle),
    .ex_branch_taken(ex_branch_taken), .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .forward_a(forward_a), .forward_b(forward_b), .ex_busy(ex_busy), .dbg_halted(dbg_halted)
  );

  // Program stream and behavioural pipeline model (one record per stage)
  instr_t prog [0:31];
  instr_t m_id, m_ex, m_mem, m_wb;
  int     m_rem, m_pc, m_mode, m_retired;

  logic halt_q, step_q, rst_q;
  int   errors = 0;
  int   checks = 0;

  // Per-cycle snapshot: {pcw,ifw,idw,flush,idex_bub,exmem_bub,fa[1:0],fb[1:0],busy,halted}
  logic [11:0] d_vec, e_vec;
  logic        c_ex_v, c_id_v, c_lu;
  logic [7:0]  c_ex_tag, c_id_tag;

  function automatic instr_t mk(int tag, int rd, int rs1, int rs2,
                                bit u1, bit u2, bit rw, bit mr, bit mc, bit br);
    instr_t i;
    i.v = 1'b1; i.tag = 8'(tag); i.rd = AW'(rd); i.rs1 = AW'(rs1); i.rs2 = AW'(rs2);
    i.u1 = u1; i.u2 = u2; i.rw = rw; i.mr = mr; i.mc = mc; i.br = br;
    return i;
  endfunction

  function automatic instr_t fetch(int pc);
    if (pc >= 0 && pc < 32) return prog[pc];
    return mk(255, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic bit mmatch(instr_t s, logic [AW-1:0] r);
    return s.v && s.rw && (s.rd == r) && !((ZR != 0) && (r == '0));
  endfunction

  function automatic logic [1:0] fsel(instr_t ex, instr_t mem, instr_t wb, logic u, logic [AW-1:0] r);
    if (!ex.v || !u)   return 2'b00;
    if (mmatch(mem, r)) return 2'b01;
    if (mmatch(wb, r))  return 2'b10;
    return 2'b00;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_id = '0; m_ex = '0; m_mem = '0; m_wb = '0;
    m_rem = 0; m_mode = M_RUN;
  endtask

  // One clock: drive from model, compare on negedge, advance model on posedge.
  task automatic tick();
    logic busy, lu, hold, drained, issue;
    logic pcw, ifw, idw, fl, ib, eb;
    logic [1:0] fa, fb;
    reset           = rst_q;
    dbg_halt_req    = halt_q;
    dbg_step        = step_q;
    id_rs1          = m_id.rs1;
    id_rs2          = m_id.rs2;
    id_use_rs1      = m_id.u1;
    id_use_rs2      = m_id.u2;
    id_rd           = m_id.rd;
    id_regwrite     = m_id.rw;
    id_memread      = m_id.mr;
    id_multicycle   = m_id.mc;
    ex_branch_taken = m_ex.v && m_ex.br;

    busy = (m_rem > 0);
    lu   = m_id.v && m_ex.mr && ((m_id.u1 && mmatch(m_ex, m_id.rs1)) ||
                                 (m_id.u2 && mmatch(m_ex, m_id.rs2)));
    hold = (m_mode == M_RUN && halt_q) || m_mode == M_DRAIN || m_mode == M_HALTED;
    pcw = 1; ifw = 1; idw = 1; fl = 0; ib = 0; eb = 0;
    if (busy) begin
      pcw = 0; ifw = 0; idw = 0; eb = 1;
    end else if (ex_branch_taken) begin
      fl = 1; ib = 1;
    end else if (lu || hold) begin
      pcw = 0; ifw = 0; ib = 1;
    end
    fa = fsel(m_ex, m_mem, m_wb, m_ex.u1, m_ex.rs1);
    fb = fsel(m_ex, m_mem, m_wb, m_ex.u2, m_ex.rs2);
    e_vec    = {pcw, ifw, idw, fl, ib, eb, fa, fb, busy, (m_mode == M_HALTED)};
    c_ex_v   = m_ex.v; c_ex_tag = m_ex.tag;
    c_id_v   = m_id.v; c_id_tag = m_id.tag;
    c_lu     = lu;

    @(negedge clk);
    d_vec = {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble,
             forward_a, forward_b, ex_busy, dbg_halted};
    if (!rst_q) check("cycle_outputs", 32'(d_vec), 32'(e_vec));

    @(posedge clk);
    if (rst_q) begin
      model_reset();
    end else begin
      drained = !m_ex.v && !m_mem.v && !m_wb.v && !busy;
      issue   = m_id.v && idw && !ib;
      case (m_mode)
        M_RUN:    if (halt_q) m_mode = M_DRAIN;
        M_DRAIN:  if (!halt_q) m_mode = M_RUN; else if (drained) m_mode = M_HALTED;
        M_HALTED: if (!halt_q) m_mode = M_RUN; else if (step_q) m_mode = M_STEP;
        default:  if (issue) m_mode = M_DRAIN;
      endcase
      m_wb = m_mem;
      if (busy) begin
        m_mem = '0;
        m_rem = m_rem - 1;
      end else begin
        m_mem = m_ex;
        if (ib) begin
          m_ex = '0; m_rem = 0;
        end else begin
          m_ex  = m_id;
          m_rem = (m_id.v && m_id.mc) ? LAT - 1 : 0;
        end
        if (fl)       m_id = '0;
        else if (ifw) m_id = fetch(m_pc);
        if (pcw) m_pc++;
      end
      if (m_wb.v) m_retired++;
    end
    #1;
  endtask

  initial begin
    int n, lu6, ib6, busy7, eb7, stall10, wrong, fl19, busy19;
    //                 tag rd rs1 rs2 u1 u2 rw mr mc br
    for (int i = 0; i < 32; i++) prog[i] = mk(i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    prog[0]  = mk(0,  1, 2, 3, 1, 1, 1, 0, 0, 0); // ADD r1
    prog[1]  = mk(1,  2, 1, 3, 1, 1, 1, 0, 0, 0); // SUB r2,r1,r3
    prog[2]  = mk(2,  1, 4, 5, 1, 1, 1, 0, 0, 0); // ADD r1
    prog[3]  = mk(3,  6, 7, 7, 1, 1, 1, 0, 0, 0); // unrelated
    prog[4]  = mk(4,  2, 1, 3, 1, 1, 1, 0, 0, 0); // SUB r2,r1,r3
    prog[5]  = mk(5,  4, 6, 0, 1, 0, 1, 1, 0, 0); // LD r4
    prog[6]  = mk(6,  5, 4, 4, 1, 1, 1, 0, 0, 0); // ADD r5,r4,r4
    prog[7]  = mk(7,  6, 5, 1, 1, 1, 1, 0, 1, 0); // MUL r6 (multi-cycle)
    prog[8]  = mk(8,  7, 6, 0, 1, 1, 1, 0, 0, 0); // ADD r7,r6,r0
    prog[9]  = mk(9,  0, 1, 0, 1, 0, 1, 1, 0, 0); // LD r0
    prog[10] = mk(10, 3, 0, 0, 1, 1, 1, 0, 0, 0); // ADD r3,r0,r0
    prog[11] = mk(11, 4, 1, 0, 1, 0, 1, 1, 0, 1); // LD r4 resolving a taken branch
    prog[12] = mk(12, 5, 4, 2, 1, 1, 1, 0, 0, 0); // load-use pending, wrong path
    prog[13] = mk(13, 6, 1, 1, 1, 1, 1, 0, 0, 0); // wrong path
    prog[14] = mk(14, 1, 2, 3, 1, 1, 1, 0, 0, 0);
    prog[15] = mk(15, 2, 1, 3, 1, 1, 1, 0, 0, 0);
    prog[16] = mk(16, 3, 2, 1, 1, 1, 1, 0, 0, 0);
    prog[19] = mk(19, 1, 2, 3, 1, 1, 1, 0, 1, 1); // multi-cycle op that also branches
    prog[22] = mk(22, 2, 1, 3, 1, 1, 1, 0, 1, 0); // multi-cycle op, reset mid-count

    model_reset();
    m_pc = 0; m_retired = 0;
    halt_q = 0; step_q = 0; rst_q = 1;
    reset = 1; dbg_halt_req = 0; dbg_step = 0; ex_branch_taken = 0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_regwrite = 0; id_memread = 0; id_multicycle = 0;

    tick(); tick();
    rst_q = 0;
    tick();
    check("reset_state", 32'(d_vec), 32'h0000_0E00);

    // Forwarding, load-use, multi-cycle, zero register, branch over load-use
    lu6 = 0; ib6 = 0; busy7 = 0; eb7 = 0; stall10 = 0; wrong = 0; n = 0;
    while (!(m_ex.v && m_ex.tag == 8'd15) && n < 200) begin
      tick(); n++;
      if (c_ex_v) begin
        case (c_ex_tag)
          8'd1:  check("fwd_b2b_a", 32'(d_vec[5:4]), 32'h1);
          8'd4:  check("fwd_gap_a", 32'(d_vec[5:4]), 32'h2);
          8'd6:  check("fwd_loaduse_ab", 32'(d_vec[5:2]), 32'hA);
          8'd7:  begin busy7 += 32'(d_vec[1]); eb7 += 32'(d_vec[6]); end
          8'd8:  check("fwd_after_mc_a", 32'(d_vec[5:4]), 32'h1);
          8'd10: check("fwd_zero_reg_ab", 32'(d_vec[5:2]), 32'h0);
          8'd11: begin
            check("branch_over_loaduse", 32'({d_vec[11], d_vec[8], d_vec[7]}), 32'h7);
            check("model_loaduse_pending", 32'(c_lu), 32'h1);
          end
          8'd12, 8'd13: wrong++;
          default: ;
        endcase
      end
      if (c_id_v && c_id_tag == 8'd6) begin
        lu6 += 32'(!d_vec[11]);
        ib6 += 32'(d_vec[7]);
      end
      if (c_id_v && c_id_tag == 8'd10) stall10 += 32'(!d_vec[11]);
    end
    check("phase_a_timeout", 32'(n < 200), 32'h1);
    check("loaduse_stall_cycles", 32'(lu6), 32'd1);
    check("loaduse_bubble_cycles", 32'(ib6), 32'd1);
    check("mc_busy_cycles", 32'(busy7), 32'd3);
    check("mc_exmem_bubble_cycles", 32'(eb7), 32'd3);
    check("zero_reg_no_stall", 32'(stall10), 32'd0);
    check("wrong_path_in_ex", 32'(wrong), 32'd0);

    // Debug: halt with instructions in flight, single step, resume
    halt_q = 1; n = 0;
    while (m_mode != M_HALTED && n < 30) begin tick(); n++; end
    check("drain_timeout", 32'(n < 30), 32'h1);
    tick();
    check("halted_after_drain", 32'(d_vec[0]), 32'h1);
    m_retired = 0;
    step_q = 1; tick(); step_q = 0;
    n = 0;
    while (m_mode != M_HALTED && n < 30) begin tick(); n++; end
    check("step_timeout", 32'(n < 30), 32'h1);
    check("step_retires_one", 32'(m_retired), 32'd1);
    tick();
    check("halted_after_step", 32'(d_vec[0]), 32'h1);
    halt_q = 0;
    tick();
    tick();
    check("resume_pc_write", 32'(d_vec[11]), 32'h1);

    // Branch ignored while busy, taken when the op leaves; then reset mid-count
    fl19 = 0; busy19 = 0; wrong = 0; n = 0;
    while (!(m_ex.v && m_ex.tag == 8'd22 && m_rem == 2) && n < 100) begin
      tick(); n++;
      if (c_ex_v && c_ex_tag == 8'd19) begin
        fl19   += 32'(d_vec[8]);
        busy19 += 32'(d_vec[1]);
      end
      if (c_ex_v && (c_ex_tag == 8'd20 || c_ex_tag == 8'd21)) wrong++;
    end
    check("phase_c_timeout", 32'(n < 100), 32'h1);
    check("busy_branch_flushes", 32'(fl19), 32'd1);
    check("busy_branch_busy_cycles", 32'(busy19), 32'd3);
    check("busy_branch_wrong_path", 32'(wrong), 32'd0);
    rst_q = 1; tick(); rst_q = 0;
    tick();
    check("reset_mid_multicycle", 32'(d_vec), 32'h0000_0E00);
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
